// File: rtl/axis_payload_buffer_if.sv
// AXI-Stream byte interface shared by the payload buffer's input and output sides.
// Latency: none, plain bundle of wires.
// Backpressure: tready flows from the slave back to the master.
interface axis_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_payload_buffer.sv
// Store-and-forward byte buffer: frames are released on m_axis only once fully stored.
// Latency: m_axis.tvalid rises 3 edges after the edge writing a frame's last byte (commit, fetch, output reg).
// Backpressure: s_axis.tready drops when full (or while padding); m_axis holds data until tready.
// Optional macro AXIS_PAYLOAD_PAD_EN: zero-pad tlast-terminated short frames up to the sampled length.
module axis_payload_buffer #(
  parameter int AXIS_DATA_WIDTH = 8,
  parameter int PAYLOAD_WIDTH   = 11,
  parameter int ADDR_WIDTH      = 12
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [PAYLOAD_WIDTH-1:0] payload_bytes_i,
  axis_if.slave                    s_axis,
  axis_if.master                   m_axis,
  output logic [ADDR_WIDTH:0]      frame_cnt_o,
  output logic                     trunc_o
);

  localparam int                     DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]    FULL_LVL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]    PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [PAYLOAD_WIDTH-1:0] LEN_ONE = {{(PAYLOAD_WIDTH-1){1'b0}}, 1'b1};

`ifdef AXIS_PAYLOAD_PAD_EN
  typedef enum logic {W_DATA, W_PAD} wstate_t;
`else
  typedef enum logic {W_DATA} wstate_t;
`endif
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_SEND} rstate_t;

  // Each entry holds {last, data}.
  logic [AXIS_DATA_WIDTH:0]   r_mem [DEPTH];

  logic [ADDR_WIDTH:0]        r_wr_ptr, r_rd_ptr, r_rel_ptr;
  logic [PAYLOAD_WIDTH-1:0]   r_wr_len, r_len;
  wstate_t                    r_wstate;
  rstate_t                    r_rstate;
  logic                       r_rdy_en;
  logic                       r_commit;
  logic                       r_trunc;
  logic [ADDR_WIDTH:0]        r_frame_cnt;
  logic                       r_m_tvalid;
  logic                       r_m_tlast;
  logic [AXIS_DATA_WIDTH-1:0] r_m_tdata;

  logic [ADDR_WIDTH:0]        w_used;
  logic                       w_full;
  logic                       w_s_rdy;
  logic                       w_s_acc;
  logic [PAYLOAD_WIDTH-1:0]   w_len_cur;
  logic [PAYLOAD_WIDTH-1:0]   w_len_inc;
  logic                       w_len_hit;
  logic                       w_we;
  logic [AXIS_DATA_WIDTH-1:0] w_wdat;
  logic                       w_close;
  logic                       w_trunc;
  logic                       w_m_hs;
  logic                       w_last_hs;
  logic                       w_rd_en;
  logic [AXIS_DATA_WIDTH:0]   w_rd_q;
`ifdef AXIS_PAYLOAD_PAD_EN
  logic                       w_pad_need;
  logic                       w_to_pad;
`endif

  // Occupancy counts bytes until they are handed off on m_axis, so a byte parked
  // in the output register still holds its slot.
  assign w_used    = r_wr_ptr - r_rel_ptr;
  assign w_full    = (w_used == FULL_LVL);
  assign w_s_rdy   = r_rdy_en & ~w_full & (r_wstate == W_DATA);
  assign w_s_acc   = s_axis.tvalid & w_s_rdy;
  assign w_len_cur = (r_wr_len == '0) ? payload_bytes_i : r_len;
  assign w_len_inc = r_wr_len + LEN_ONE;
  assign w_len_hit = (w_len_cur != '0) && (w_len_inc == w_len_cur);
`ifdef AXIS_PAYLOAD_PAD_EN
  assign w_pad_need = s_axis.tlast & (w_len_cur != '0) & ~w_len_hit;
`endif

  assign s_axis.tready = w_s_rdy;
  assign m_axis.tvalid = r_m_tvalid;
  assign m_axis.tdata  = r_m_tdata;
  assign m_axis.tlast  = r_m_tlast;
  assign frame_cnt_o   = r_frame_cnt;
  assign trunc_o       = r_trunc;

  // Decide what (if anything) is written this cycle and whether it closes the frame.
  always_comb begin
    w_we    = 1'b0;
    w_wdat  = s_axis.tdata;
    w_close = 1'b0;
    w_trunc = 1'b0;
`ifdef AXIS_PAYLOAD_PAD_EN
    w_to_pad = 1'b0;
`endif
    if (r_wstate == W_DATA) begin
      if (w_s_acc) begin
        w_we    = 1'b1;
        w_close = s_axis.tlast | w_len_hit;
        w_trunc = w_len_hit & ~s_axis.tlast;
`ifdef AXIS_PAYLOAD_PAD_EN
        if (w_pad_need) begin
          w_close  = 1'b0;
          w_to_pad = 1'b1;
        end
`endif
      end
    end
`ifdef AXIS_PAYLOAD_PAD_EN
    else if (!w_full) begin
      w_we    = 1'b1;
      w_wdat  = '0;
      w_close = w_len_hit;
    end
`endif
  end

  // Buffer RAM write port; the closing byte carries the last flag.
  always_ff @(posedge clk_i) begin
    if (w_we) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= {w_close, w_wdat};
  end

  // Write side: pointer, frame length tracking, commit/truncation pulses and pad FSM.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_wr_len <= '0;
      r_len    <= '0;
      r_wstate <= W_DATA;
      r_rdy_en <= 1'b0;
      r_commit <= 1'b0;
      r_trunc  <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      r_commit <= w_close;
      r_trunc  <= w_trunc;
      if (w_we) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (r_wr_len == '0) r_len <= payload_bytes_i;
        r_wr_len <= w_close ? '0 : w_len_inc;
      end
`ifdef AXIS_PAYLOAD_PAD_EN
      if (w_to_pad)     r_wstate <= W_PAD;
      else if (w_close) r_wstate <= W_DATA;
`endif
    end
  end

  assign w_m_hs    = r_m_tvalid & m_axis.tready;
  assign w_last_hs = w_m_hs & r_m_tlast;
  assign w_rd_en   = (r_rstate == R_FETCH) | (w_m_hs & ~r_m_tlast);
  assign w_rd_q    = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];

  // Read side: fetch a committed frame into the output register and stream it without bubbles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rstate   <= R_IDLE;
      r_rd_ptr   <= '0;
      r_rel_ptr  <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tdata  <= '0;
    end else begin
      if (w_m_hs) r_rel_ptr <= r_rel_ptr + PTR_ONE;
      if (w_rd_en) begin
        r_rd_ptr               <= r_rd_ptr + PTR_ONE;
        {r_m_tlast, r_m_tdata} <= w_rd_q;
      end
      case (r_rstate)
        R_IDLE: begin
          if (r_frame_cnt != '0) r_rstate <= R_FETCH;
        end
        R_FETCH: begin
          r_m_tvalid <= 1'b1;
          r_rstate   <= R_SEND;
        end
        R_SEND: begin
          if (w_last_hs) begin
            r_m_tvalid <= 1'b0;
            r_rstate   <= ((r_frame_cnt != PTR_ONE) || r_commit) ? R_FETCH : R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // Complete-frame count: a commit and a frame leaving in the same cycle cancel out.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_frame_cnt <= '0;
    end else begin
      case ({r_commit, w_last_hs})
        2'b10:   r_frame_cnt <= r_frame_cnt + PTR_ONE;
        2'b01:   r_frame_cnt <= r_frame_cnt - PTR_ONE;
        default: r_frame_cnt <= r_frame_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_payload_buffer.sv
// Bench for axis_payload_buffer: directed and random frames against a frame-splitting model.
// Latency: checks the 3-edge commit-to-tvalid delay and back-to-back output.
// Backpressure: exercises full buffer, held m_axis.tready and random m_axis.tready.
module tb_axis_payload_buffer;
  localparam int PW = 4;
  localparam int AW = 4;

  typedef struct packed {
    logic [7:0]    d;
    logic          l;
    logic [PW-1:0] p;
  } in_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] plen = '0;
  logic [AW:0]   frame_cnt;
  logic          trunc;

  axis_if #(.DATA_WIDTH(8)) s_if ();
  axis_if #(.DATA_WIDTH(8)) m_if ();

  axis_payload_buffer #(
    .AXIS_DATA_WIDTH(8),
    .PAYLOAD_WIDTH  (PW),
    .ADDR_WIDTH     (AW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .payload_bytes_i(plen),
    .s_axis         (s_if),
    .m_axis         (m_if),
    .frame_cnt_o    (frame_cnt),
    .trunc_o        (trunc)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  in_t        in_q[$];
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  int         exp_trunc;
  int         trunc_seen = 0;
  int         rdy_mode = 0;
  logic [AW:0] prev_cnt;
  bit         prev_ok = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // m_axis.tready generator: 0 = always ready, 1 = never ready, 2 = random.
  initial begin
    m_if.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_if.tready = 1'b1;
        1:       m_if.tready = 1'b0;
        default: m_if.tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output capture, trunc pulse counting and frame counter step check.
  always @(negedge clk) begin
    if (rst) begin
      prev_ok = 0;
    end else begin
      logic [AW:0] diff;
      if (m_if.tvalid && m_if.tready) got_q.push_back({m_if.tlast, m_if.tdata});
      if (trunc) trunc_seen++;
      if (prev_ok) begin
        diff = frame_cnt - prev_cnt;
        check("cnt_step", (diff == 0 || diff == 1 || diff == '1), 1);
      end
      prev_cnt = frame_cnt;
      prev_ok  = 1;
    end
  end

  // Reference: split the accepted byte log into frames by tlast / sampled length.
  task automatic run_model();
    logic [7:0] fr[$];
    int lim;
    exp_q.delete();
    exp_trunc = 0;
    lim = 0;
    foreach (in_q[i]) begin
      if (fr.size() == 0) lim = int'(in_q[i].p);
      fr.push_back(in_q[i].d);
      if (in_q[i].l || (lim != 0 && fr.size() == lim)) begin
        if (!in_q[i].l) exp_trunc++;
`ifdef AXIS_PAYLOAD_PAD_EN
        while (lim != 0 && fr.size() < lim) fr.push_back(8'h00);
`endif
        foreach (fr[j]) exp_q.push_back({(j == fr.size() - 1), fr[j]});
        fr.delete();
      end
    end
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    int  n;
    bit  acc;
    in_t e;
    s_if.tdata  = d;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    n   = 0;
    acc = 0;
    while (!acc && n < 2000) begin
      @(negedge clk);
      if (s_if.tready) begin
        @(posedge clk);
        acc = 1;
      end
      n++;
    end
    check($sformatf("push_accept_%0h", d), acc, 1);
    e.d = d;
    e.l = l;
    e.p = plen;
    if (acc) in_q.push_back(e);
    #1;
    s_if.tvalid = 1'b0;
  endtask

  task automatic compare_phase(input string tag);
    int n;
    run_model();
    n = 0;
    while (got_q.size() < exp_q.size() && n < 4000) begin
      @(posedge clk);
      n++;
    end
    repeat (8) @(posedge clk);
    #1;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    check({tag, "_trunc"}, trunc_seen, exp_trunc);
    check({tag, "_cnt_idle"}, frame_cnt, 0);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    in_q.delete();
    got_q.delete();
    trunc_seen = 0;
  endtask

  initial begin
    int lat;
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_tready", s_if.tready, 0);
    check("rst_m_tvalid", m_if.tvalid, 0);
    check("rst_m_tdata", m_if.tdata, 0);
    check("rst_m_tlast", m_if.tlast, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_trunc", trunc, 0);
    rst = 1'b0;
    #1;
    check("rdy_before_edge", s_if.tready, 0);
    @(posedge clk);
    #1;
    check("rdy_after_edge", s_if.tready, 1);

    // Exact-length frame: latency, counter and back-to-back output
    plen = 4'd4;
    push(8'h11, 0); push(8'h12, 0); push(8'h13, 0); push(8'h14, 1);
    check("t1_cnt_e0", frame_cnt, 0);
    check("t1_valid_e0", m_if.tvalid, 0);
    lat = 0;
    while (!m_if.tvalid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) check("t1_cnt_e1", frame_cnt, 1);
    end
    check("t1_latency", lat, 3);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_b2b%0d", i), m_if.tvalid, 1);
      @(posedge clk);
      #1;
    end
    check("t1_valid_end", m_if.tvalid, 0);
    check("t1_cnt_end", frame_cnt, 0);
    compare_phase("t1");

    // Length truncation
    plen = 4'd4;
    push(8'h01, 0); push(8'h02, 0); push(8'h03, 0); push(8'h04, 0);
    check("t2_trunc_pulse", trunc, 1);
    push(8'h05, 0);
    check("t2_trunc_width", trunc, 0);
    push(8'h06, 1);
    compare_phase("t2");

    // Short frame
    plen = 4'd4;
    push(8'hAA, 0); push(8'hBB, 1);
`ifdef AXIS_PAYLOAD_PAD_EN
    check("t3_pad_rdy0", s_if.tready, 0);
    @(posedge clk);
    #1;
    check("t3_pad_rdy1", s_if.tready, 0);
    @(posedge clk);
    #1;
    check("t3_pad_rdy2", s_if.tready, 1);
`else
    check("t3_rdy", s_if.tready, 1);
`endif
    compare_phase("t3");

    // Full buffer with output stalled
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    plen = 4'd4;
    for (int i = 0; i < 16; i++) push(8'h40 + 8'(i), (i % 4) == 3);
    check("t4_full_rdy", s_if.tready, 0);
    repeat (4) @(posedge clk);
    #1;
    check("t4_cnt4", frame_cnt, 4);
    check("t4_still_full", s_if.tready, 0);
    check("t4_no_out", got_q.size(), 0);
    rdy_mode = 0;
    for (int i = 16; i < 20; i++) push(8'h40 + 8'(i), (i % 4) == 3);
    compare_phase("t4");

    // Random frames, random lengths, random gaps and random backpressure
    rdy_mode = 2;
    for (int f = 0; f < 1000; f++) begin
      int n;
      n = $urandom_range(1, 12);
      for (int b = 0; b < n; b++) begin
        int gap;
        plen = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        gap  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        if (gap != 0) begin
          repeat (gap) @(posedge clk);
          #1;
        end
        push(8'($urandom), b == n - 1);
      end
    end
    compare_phase("t5");

    // Reset mid-frame
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    plen = 4'd4;
    push(8'hC1, 0); push(8'hC2, 0); push(8'hC3, 0); push(8'hC4, 1);
    repeat (5) @(posedge clk);
    #1;
    check("t6_pre_valid", m_if.tvalid, 1);
    check("t6_pre_data", m_if.tdata, 8'hC1);
    push(8'hD1, 0); push(8'hD2, 0);
    #1;
    rst = 1'b1;
    #1;
    check("t6_rst_s_tready", s_if.tready, 0);
    check("t6_rst_m_tvalid", m_if.tvalid, 0);
    check("t6_rst_m_tdata", m_if.tdata, 0);
    check("t6_rst_m_tlast", m_if.tlast, 0);
    check("t6_rst_cnt", frame_cnt, 0);
    check("t6_rst_trunc", trunc, 0);
    in_q.delete();
    got_q.delete();
    trunc_seen = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    push(8'hE1, 0); push(8'hE2, 0); push(8'hE3, 0); push(8'hE4, 1);
    compare_phase("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
